// File: rtl/hall_spin_ctrl.sv
// hall_spin_ctrl: spinning-current phase sequencer with blanking, per-phase
// sign demodulation of ADC samples, multi-spin integration and a
// valid/ready result register with a sticky overrun flag.
module hall_spin_ctrl #(
    parameter int unsigned NPHASES   = 4,
    parameter int unsigned TPHASE    = 64,
    parameter int unsigned TBLANK    = 4,
    parameter int unsigned NSPIN     = 4,
    parameter int unsigned DW        = 12,
    parameter int unsigned ACCW      = 24,
    parameter logic [3:0]  SIGN_MASK = 4'b1100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [DW-1:0]   adc_data,
    input  logic            adc_valid,
    output logic [3:0]      phases,
    output logic            phases_update,
    output logic [ACCW-1:0] out_data,
    output logic [15:0]     out_count,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            overrun
);

    localparam int unsigned CW      = $clog2(TPHASE);
    localparam int unsigned SW      = (NSPIN > 1) ? $clog2(NSPIN) : 1;
    localparam int unsigned PSTEP   = (NPHASES == 2) ? 2 : 1;
    localparam int unsigned LAST_PH = (NPHASES == 2) ? 2 : 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_ACQ   = 2'd2;

    logic [1:0]      state_q,   state_d;
    logic [1:0]      phase_q,   phase_d;
    logic [CW-1:0]   cyc_q,     cyc_d;
    logic [SW-1:0]   spin_q,    spin_d;
    logic [ACCW-1:0] acc_q,     acc_d;
    logic [15:0]     cnt_q,     cnt_d;
    logic [3:0]      phases_q,  phases_d;
    logic            upd_q,     upd_d;
    logic [ACCW-1:0] odata_q,   odata_d;
    logic [15:0]     ocount_q,  ocount_d;
    logic            ovalid_q,  ovalid_d;
    logic            overrun_q, overrun_d;

    logic            win_end;
    logic [ACCW-1:0] win_data;
    logic [15:0]     win_count;
    logic [ACCW-1:0] sample_ext;
    logic [ACCW-1:0] sample_term;
    logic [15:0]     cnt_inc;

    // Sign-extend the sample and apply the demodulation sign of the active phase
    always_comb begin
        sample_ext  = {{(ACCW-DW){adc_data[DW-1]}}, adc_data};
        sample_term = SIGN_MASK[phase_q] ? (ACCW'(0) - sample_ext) : sample_ext;
        cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);
    end

    // Phase sequencer and integrator next-state logic
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cyc_d     = cyc_q;
        spin_d    = spin_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        phases_d  = phases_q;
        upd_d     = 1'b0;
        win_end   = 1'b0;
        win_data  = acc_q;
        win_count = cnt_q;

        case (state_q)
            S_IDLE: begin
                phases_d = 4'b0000;
                if (en) begin
                    state_d  = S_BLANK;
                    phase_d  = 2'd0;
                    cyc_d    = '0;
                    spin_d   = '0;
                    acc_d    = '0;
                    cnt_d    = '0;
                    phases_d = 4'b0001;
                    upd_d    = 1'b1;
                end
            end

            S_BLANK: begin
                if (!en) begin
                    state_d  = S_IDLE;
                    phases_d = 4'b0000;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                    if (cyc_q == CW'(TBLANK - 1)) begin
                        state_d = S_ACQ;
                    end
                end
            end

            S_ACQ: begin
                if (!en) begin
                    state_d  = S_IDLE;
                    phases_d = 4'b0000;
                end else begin
                    if (adc_valid) begin
                        acc_d = acc_q + sample_term;
                        cnt_d = cnt_inc;
                    end
                    if (cyc_q == CW'(TPHASE - 1)) begin
                        cyc_d   = '0;
                        state_d = S_BLANK;
                        upd_d   = 1'b1;
                        if (phase_q == 2'(LAST_PH)) begin
                            phase_d  = 2'd0;
                            phases_d = 4'b0001;
                            if (spin_q == SW'(NSPIN - 1)) begin
                                // Window complete: hand the total (final sample included) to the output stage
                                win_end   = 1'b1;
                                win_data  = acc_d;
                                win_count = cnt_d;
                                acc_d     = '0;
                                cnt_d     = '0;
                                spin_d    = '0;
                            end else begin
                                spin_d = spin_q + SW'(1);
                            end
                        end else begin
                            phase_d  = phase_q + 2'(PSTEP);
                            phases_d = 4'b0001 << phase_d;
                        end
                    end else begin
                        cyc_d = cyc_q + CW'(1);
                    end
                end
            end

            default: begin
                state_d  = S_IDLE;
                phases_d = 4'b0000;
            end
        endcase
    end

    // Result register: load when empty or being drained, otherwise drop and flag overrun
    always_comb begin
        odata_d   = odata_q;
        ocount_d  = ocount_q;
        ovalid_d  = ovalid_q;
        overrun_d = overrun_q;
        if (ovalid_q && out_ready) begin
            ovalid_d = 1'b0;
        end
        if (win_end) begin
            if (!ovalid_q || out_ready) begin
                odata_d  = win_data;
                ocount_d = win_count;
                ovalid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            phase_q   <= 2'd0;
            cyc_q     <= '0;
            spin_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            phases_q  <= 4'b0000;
            upd_q     <= 1'b0;
            odata_q   <= '0;
            ocount_q  <= '0;
            ovalid_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cyc_q     <= cyc_d;
            spin_q    <= spin_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            phases_q  <= phases_d;
            upd_q     <= upd_d;
            odata_q   <= odata_d;
            ocount_q  <= ocount_d;
            ovalid_q  <= ovalid_d;
            overrun_q <= overrun_d;
        end
    end

    assign phases        = phases_q;
    assign phases_update = upd_q;
    assign out_data      = odata_q;
    assign out_count     = ocount_q;
    assign out_valid     = ovalid_q;
    assign overrun       = overrun_q;

endmodule
